// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS memory-access stage with local data memory and MEM/WB latch
module mem_wb_stage #(
   parameter int ADDR_W          = 10,
   parameter bit ZERO_FAULT_DATA = 1'b1
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        FlushSignal,
   input  logic        Stall,
   input  logic        inMemWrite,
   input  logic        inMemRead,
   input  logic [1:0]  inMemSize,
   input  logic        inLoadUnsigned,
   input  logic [2:0]  inMemtoReg,
   input  logic        inRegWrite,
   input  logic [31:0] inALUResult,
   input  logic [31:0] inReadData2,
   input  logic [4:0]  inWriteReg,
   input  logic [31:0] PCplus4In,
   input  logic [31:0] ShiftLeft16In,
   output logic        outRegWrite,
   output logic [4:0]  outWriteReg,
   output logic [31:0] outWriteData,
   output logic [31:0] outMemData,
   output logic [31:0] outALUResult,
   output logic        MisalignFault
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Word-organised data memory; never reset so contents survive Rst_n
   logic [31:0] memArray [0:DEPTH-1];

   logic [ADDR_W-1:0] wordIdx;
   logic [1:0]        byteOff;
   logic              isByte;
   logic              isHalf;
   logic              badAlign;
   logic              misalign;
   logic              storeEn;
   logic [3:0]        laneEn;
   logic [31:0]       storeWord;
   logic [31:0]       rdWord;
   logic [31:0]       byteShift;
   logic [31:0]       halfShift;
   logic [31:0]       loadData;
   logic [31:0]       wbData;
   logic [31:0]       nextWriteData;

   // Address decode, alignment check, store lane steering and load extraction
   always_comb begin
      wordIdx   = inALUResult[ADDR_W+1:2];
      byteOff   = inALUResult[1:0];
      isByte    = (inMemSize == 2'b10);
      isHalf    = (inMemSize == 2'b01);
      badAlign  = 1'b0;
      laneEn    = 4'b1111;
      storeWord = inReadData2;
      loadData  = 32'd0;

      if (isHalf) begin
         badAlign = byteOff[0];
      end else if (!isByte) begin
         badAlign = (byteOff != 2'b00);
      end
      misalign = badAlign & (inMemRead | inMemWrite);

      // An in-flight store is dropped while reset is asserted
      storeEn = inMemWrite & ~Stall & ~FlushSignal & ~misalign & Rst_n;

      if (isByte) begin
         laneEn    = 4'b0001 << byteOff;
         storeWord = {4{inReadData2[7:0]}};
      end else if (isHalf) begin
         laneEn    = byteOff[1] ? 4'b1100 : 4'b0011;
         storeWord = {2{inReadData2[15:0]}};
      end

      rdWord    = memArray[wordIdx];
      byteShift = rdWord >> {byteOff, 3'b000};
      halfShift = rdWord >> {byteOff[1], 4'b0000};

      if (isByte) begin
         loadData = inLoadUnsigned ? {24'd0, byteShift[7:0]}
                                   : {{24{byteShift[7]}}, byteShift[7:0]};
      end else if (isHalf) begin
         loadData = inLoadUnsigned ? {16'd0, halfShift[15:0]}
                                   : {{16{halfShift[15]}}, halfShift[15:0]};
      end else begin
         loadData = rdWord;
      end

      case (inMemtoReg)
         3'b001:  wbData = loadData;
         3'b010:  wbData = PCplus4In;
         3'b011:  wbData = ShiftLeft16In;
         default: wbData = inALUResult;
      endcase

      if (misalign) begin
         nextWriteData = ZERO_FAULT_DATA ? 32'd0 : inALUResult;
      end else begin
         nextWriteData = wbData;
      end
   end

   // Byte-lane masked store; read above sees pre-write contents in the same cycle
   always_ff @(posedge Clk) begin
      if (storeEn) begin
         for (int k = 0; k < 4; k++) begin
            if (laneEn[k]) begin
               memArray[wordIdx][8*k +: 8] <= storeWord[8*k +: 8];
            end
         end
      end
   end

   // MEM/WB latch: reset, then flush squashes, then stall holds, else capture
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         outRegWrite   <= 1'b0;
         outWriteReg   <= 5'd0;
         outWriteData  <= 32'd0;
         outMemData    <= 32'd0;
         outALUResult  <= 32'd0;
         MisalignFault <= 1'b0;
      end else if (FlushSignal) begin
         outRegWrite   <= 1'b0;
         outWriteReg   <= 5'd0;
         outWriteData  <= 32'd0;
         outMemData    <= 32'd0;
         outALUResult  <= 32'd0;
         MisalignFault <= 1'b0;
      end else if (!Stall) begin
         outRegWrite   <= inRegWrite & ~misalign;
         outWriteReg   <= inWriteReg;
         outWriteData  <= nextWriteData;
         outMemData    <= loadData;
         outALUResult  <= inALUResult;
         MisalignFault <= misalign;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

   logic        Clk;
   logic        Rst_n;
   logic        FlushSignal;
   logic        Stall;
   logic        inMemWrite;
   logic        inMemRead;
   logic [1:0]  inMemSize;
   logic        inLoadUnsigned;
   logic [2:0]  inMemtoReg;
   logic        inRegWrite;
   logic [31:0] inALUResult;
   logic [31:0] inReadData2;
   logic [4:0]  inWriteReg;
   logic [31:0] PCplus4In;
   logic [31:0] ShiftLeft16In;
   logic        outRegWrite;
   logic [4:0]  outWriteReg;
   logic [31:0] outWriteData;
   logic [31:0] outMemData;
   logic [31:0] outALUResult;
   logic        MisalignFault;

   int nChecks = 0;
   int nPass   = 0;

   // Byte-addressed reference memory (4 KiB = 2**10 words)
   logic [7:0] refMem [0:4095];

   logic        expRegWrite;
   logic [4:0]  expWriteReg;
   logic [31:0] expWriteData;
   logic [31:0] expMemData;
   logic [31:0] expALUResult;
   logic        expFault;
   logic        expMemValid;

   mem_wb_stage #(.ADDR_W(10), .ZERO_FAULT_DATA(1'b1)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .FlushSignal(FlushSignal), .Stall(Stall),
      .inMemWrite(inMemWrite), .inMemRead(inMemRead), .inMemSize(inMemSize),
      .inLoadUnsigned(inLoadUnsigned), .inMemtoReg(inMemtoReg), .inRegWrite(inRegWrite),
      .inALUResult(inALUResult), .inReadData2(inReadData2), .inWriteReg(inWriteReg),
      .PCplus4In(PCplus4In), .ShiftLeft16In(ShiftLeft16In),
      .outRegWrite(outRegWrite), .outWriteReg(outWriteReg), .outWriteData(outWriteData),
      .outMemData(outMemData), .outALUResult(outALUResult), .MisalignFault(MisalignFault)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
   endtask

   task automatic clearExp();
      expRegWrite  = 1'b0;
      expWriteReg  = 5'd0;
      expWriteData = 32'd0;
      expMemData   = 32'd0;
      expALUResult = 32'd0;
      expFault     = 1'b0;
      expMemValid  = 1'b1;
   endtask

   task automatic checkOutputs(input string tag);
      checkVal({tag, ".regwrite"}, 32'(outRegWrite), 32'(expRegWrite));
      checkVal({tag, ".writereg"}, 32'(outWriteReg), 32'(expWriteReg));
      checkVal({tag, ".writedata"}, outWriteData, expWriteData);
      checkVal({tag, ".aluresult"}, outALUResult, expALUResult);
      checkVal({tag, ".fault"}, 32'(MisalignFault), 32'(expFault));
      if (expMemValid) checkVal({tag, ".memdata"}, outMemData, expMemData);
   endtask

   // Apply one clock of the current inputs to the reference model, then compare
   task automatic step(input string tag);
      int a;
      int base;
      logic [31:0] ld;
      logic [31:0] wb;
      logic [15:0] h;
      logic        fault;
      a = int'(inALUResult[11:0]);
      case (inMemSize)
         2'b10: ld = inLoadUnsigned ? {24'd0, refMem[a]} : {{24{refMem[a][7]}}, refMem[a]};
         2'b01: begin
            base = a - (a % 2);
            h = {refMem[base+1], refMem[base]};
            ld = inLoadUnsigned ? {16'd0, h} : {{16{h[15]}}, h};
         end
         default: begin
            base = a - (a % 4);
            ld = {refMem[base+3], refMem[base+2], refMem[base+1], refMem[base]};
         end
      endcase
      fault = (inMemRead || inMemWrite) &&
              ((inMemSize == 2'b01 && (a % 2) != 0) ||
               ((inMemSize == 2'b00 || inMemSize == 2'b11) && (a % 4) != 0));
      case (inMemtoReg)
         3'd1:    wb = ld;
         3'd2:    wb = PCplus4In;
         3'd3:    wb = ShiftLeft16In;
         default: wb = inALUResult;
      endcase
      if (!Rst_n || FlushSignal) begin
         clearExp();
      end else if (!Stall) begin
         expRegWrite  = inRegWrite && !fault;
         expWriteReg  = inWriteReg;
         expWriteData = fault ? 32'd0 : wb;
         expMemData   = ld;
         expALUResult = inALUResult;
         expFault     = fault;
         expMemValid  = inMemRead && !fault;
         if (inMemWrite && !fault) begin
            case (inMemSize)
               2'b10: refMem[a] = inReadData2[7:0];
               2'b01: begin
                  base = a - (a % 2);
                  refMem[base]   = inReadData2[7:0];
                  refMem[base+1] = inReadData2[15:8];
               end
               default: begin
                  base = a - (a % 4);
                  for (int i = 0; i < 4; i++) refMem[base+i] = inReadData2[8*i +: 8];
               end
            endcase
         end
      end
      @(posedge Clk);
      #1;
      checkOutputs(tag);
   endtask

   task automatic setOp(input logic wr, input logic rd, input logic [1:0] size,
                        input logic uns, input logic [2:0] m2r, input logic rw,
                        input logic [31:0] addr, input logic [31:0] data, input logic [4:0] dst);
      inMemWrite     = wr;
      inMemRead      = rd;
      inMemSize      = size;
      inLoadUnsigned = uns;
      inMemtoReg     = m2r;
      inRegWrite     = rw;
      inALUResult    = addr;
      inReadData2    = data;
      inWriteReg     = dst;
      Stall          = 1'b0;
      FlushSignal    = 1'b0;
   endtask

   initial begin
      Rst_n = 1'b0;
      setOp(0, 0, 2'd0, 0, 3'd0, 0, 32'd0, 32'd0, 5'd0);
      PCplus4In = 32'd0;
      ShiftLeft16In = 32'd0;
      clearExp();
      repeat (2) @(posedge Clk);
      #1;
      checkOutputs("reset_init");
      Rst_n = 1'b1;

      // Preload words 0..63 through the DUT so every later load has known data
      for (int w = 0; w < 64; w++) begin
         setOp(1, 0, 2'd0, 0, 3'd0, 0, 32'(w * 4), $urandom(), 5'd0);
         step("preload");
      end

      setOp(1, 0, 2'd0, 0, 3'd0, 0, 32'h10, 32'hDEADBEEF, 5'd0); step("sw10");
      setOp(0, 1, 2'd0, 0, 3'd1, 1, 32'h10, 32'd0, 5'd8);         step("lw10");
      checkVal("lw_word", outWriteData, 32'hDEADBEEF);
      checkVal("lw_regwrite", 32'(outRegWrite), 32'd1);
      checkVal("lw_writereg", 32'(outWriteReg), 32'd8);

      setOp(1, 0, 2'd2, 0, 3'd0, 0, 32'h13, 32'h80, 5'd0);        step("sb13");
      setOp(0, 1, 2'd2, 0, 3'd1, 1, 32'h13, 32'd0, 5'd9);         step("lb13");
      checkVal("lb_signed", outWriteData, 32'hFFFFFF80);
      setOp(0, 1, 2'd2, 1, 3'd1, 1, 32'h13, 32'd0, 5'd9);         step("lbu13");
      checkVal("lbu", outWriteData, 32'h00000080);
      setOp(0, 1, 2'd0, 0, 3'd1, 1, 32'h10, 32'd0, 5'd9);         step("lw10b");
      checkVal("lw_after_sb", outWriteData, 32'h80ADBEEF);
      setOp(1, 0, 2'd1, 0, 3'd0, 0, 32'h12, 32'h1234, 5'd0);      step("sh12");
      setOp(0, 1, 2'd0, 0, 3'd1, 1, 32'h10, 32'd0, 5'd9);         step("lw10c");
      checkVal("lw_after_sh", outWriteData, 32'h1234BEEF);

      setOp(1, 0, 2'd0, 0, 3'd0, 1, 32'h22, 32'h99999999, 5'd4);  step("sw22_mis");
      checkVal("mis_fault", 32'(MisalignFault), 32'd1);
      checkVal("mis_regwrite", 32'(outRegWrite), 32'd0);
      checkVal("mis_data", outWriteData, 32'd0);
      setOp(0, 1, 2'd0, 0, 3'd1, 1, 32'h20, 32'd0, 5'd4);         step("lw20");
      setOp(0, 1, 2'd1, 0, 3'd1, 1, 32'h21, 32'd0, 5'd4);         step("lh21_mis");
      checkVal("lh_fault", 32'(MisalignFault), 32'd1);

      setOp(0, 1, 2'd0, 0, 3'd1, 1, 32'h30, 32'd0, 5'd7);         step("lw30");
      setOp(1, 0, 2'd0, 0, 3'd0, 1, 32'h30, 32'h55, 5'd3);
      Stall = 1'b1;                                               step("sw30_stall");
      setOp(1, 0, 2'd0, 0, 3'd0, 1, 32'h30, 32'h55, 5'd3);
      Stall = 1'b1; FlushSignal = 1'b1;                           step("sw30_flush");
      checkVal("flush_regwrite", 32'(outRegWrite), 32'd0);
      checkVal("flush_data", outWriteData, 32'd0);
      setOp(0, 1, 2'd0, 0, 3'd1, 1, 32'h30, 32'd0, 5'd7);         step("lw30b");

      setOp(0, 0, 2'd0, 0, 3'd2, 1, 32'h44, 32'd0, 5'd31);
      PCplus4In = 32'h400;                                        step("m2r_pc");
      checkVal("mux_pc4", outWriteData, 32'h400);
      setOp(0, 0, 2'd0, 0, 3'd3, 1, 32'h44, 32'd0, 5'd31);
      ShiftLeft16In = 32'hABCD0000;                               step("m2r_lui");
      checkVal("mux_lui", outWriteData, 32'hABCD0000);

      setOp(1, 0, 2'd0, 0, 3'd0, 0, 32'h1000, 32'hCAFEF00D, 5'd0); step("sw1000");
      setOp(0, 1, 2'd0, 0, 3'd1, 1, 32'h0, 32'd0, 5'd2);           step("lw0");
      checkVal("wrap_alias", outWriteData, 32'hCAFEF00D);

      // Asynchronous reset mid-stream with a store pending
      setOp(1, 1, 2'd0, 1, 3'd1, 1, 32'h14, 32'h11111111, 5'd5);
      PCplus4In = 32'h1234; ShiftLeft16In = 32'h5678;
      #2;
      Rst_n = 1'b0;
      #1;
      clearExp();
      checkOutputs("reset_async");
      step("reset_held");
      Rst_n = 1'b1;
      setOp(0, 1, 2'd0, 0, 3'd1, 1, 32'h14, 32'd0, 5'd5);         step("lw14_post_reset");

      for (int n = 0; n < 400; n++) begin
         logic [31:0] addr;
         logic [2:0]  kind;
         addr = {$urandom_range(0, 32'hFFFFF) << 12} | 32'($urandom_range(0, 255));
         kind = 3'($urandom_range(0, 7));
         setOp(kind < 3, (kind >= 3 && kind < 6) || kind == 7, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               addr, $urandom(), 5'($urandom_range(0, 31)));
         PCplus4In     = $urandom();
         ShiftLeft16In = $urandom() & 32'hFFFF0000;
         Stall         = ($urandom_range(0, 9) == 0);
         FlushSignal   = ($urandom_range(0, 9) == 0);
         step("random");
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline latch of the pipelined MIPS datapath.
- Sits directly downstream of the EX/MEM register: consumes its ALU result, store data, destination register, PC+4, shifted-immediate and control outputs.
- Performs word/half/byte loads and stores on a local data memory.
- Registers the selected write-back value and control for the register-file write in WB.

Parameters:
- ADDR_W, 10, word-address width; memory holds 2**ADDR_W 32-bit words.
- ZERO_FAULT_DATA, 1, when 1 a faulting access writes 0 to outWriteData; when 0 it writes the ALU result.

Ports:
- Clk  in  1  clock; all state changes on posedge
- Rst_n  in  1  asynchronous active-low reset
- FlushSignal  in  1  squash the instruction entering MEM this cycle
- Stall  in  1  hold the MEM/WB latch and suppress stores
- inMemWrite  in  1  store enable
- inMemRead  in  1  load enable
- inMemSize  in  2  00 word, 01 halfword, 10 byte, 11 treated as word
- inLoadUnsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
- inMemtoReg  in  3  write-back select
- inRegWrite  in  1  register write enable
- inALUResult  in  32  byte address, or ALU value
- inReadData2  in  32  store data (low bits used for sub-word stores)
- inWriteReg  in  5  destination register number
- PCplus4In  in  32  link value
- ShiftLeft16In  in  32  LUI value
- outRegWrite  out  1  registered write enable to WB
- outWriteReg  out  5  registered destination register
- outWriteData  out  32  registered write-back value
- outMemData  out  32  registered extended load data (for debug/forwarding)
- outALUResult  out  32  registered ALU result (forwarding)
- MisalignFault  out  1  registered fault flag for the instruction now in WB

Behaviour:
- Reset (Rst_n=0, async): every output is 0; memory contents are not cleared.
- Priority: reset > FlushSignal > Stall > normal.
- Byte address is A = inALUResult. Word index is A[ADDR_W+1:2]; upper bits are ignored, so addresses wrap modulo the memory size. Lanes are little-endian: byte k is bits [8k+7:8k].
- Misalign: a halfword access with A[0]=1, or a word access with A[1:0]!=0, is misaligned when inMemRead or inMemWrite is set.
- On a misaligned access:
  - The store is suppressed.
  - The latched outRegWrite is 0 and MisalignFault is 1.
  - outWriteData follows ZERO_FAULT_DATA.
- Stores commit at posedge when inMemWrite=1, Stall=0, FlushSignal=0 and the access is aligned. Only the addressed lanes are written:
  - byte: byte 0 of inReadData2 goes to lane A[1:0];
  - half: bits [15:0] go to lanes A[1]*2 and A[1]*2+1;
  - word: all four lanes.
- Loads read the memory combinationally at word index A. Lane extraction and extension use inMemSize and inLoadUnsigned. The result is latched into outMemData at posedge, so a load has 1-cycle latency from EX/MEM output to WB-visible data.
- Read and write in the same cycle (illegal encoding): the write commits and outMemData reflects the pre-write contents (read-before-write).
- A store at posedge k followed by a load of the same address is visible to that load at posedge k+1. No bypass is needed inside the block.
- Write-back select for outWriteData:
  - 000: inALUResult
  - 001: extended load data
  - 010: PCplus4In
  - 011: ShiftLeft16In
  - any other value: inALUResult
- Normal cycle: all outputs load their next values.
- Stall=1: all outputs hold and stores are suppressed. A stalled load re-reads and re-latches nothing.
- FlushSignal=1, taking precedence over Stall:
  - outRegWrite, outWriteReg and MisalignFault load 0;
  - data outputs load 0;
  - the store is suppressed.
- Rst_n deasserted mid-stream: the next posedge performs a normal capture. An in-flight store at the asserting edge is lost.

Test Plan:
- Reset: drive inputs nonzero with Rst_n=0 -> all outputs 0 immediately, with no clock edge.
- Word store/load: store 0xDEADBEEF at A=0x10, then load a word at 0x10 with MemtoReg=001, RegWrite=1, WriteReg=8 -> one cycle later outWriteData=0xDEADBEEF, outRegWrite=1, outWriteReg=8.
- Sub-word: store byte 0x80 at A=0x13, then lb 0x13 -> 0xFFFFFF80; lbu -> 0x00000080; lw 0x10 -> 0x80ADBEEF. Then sh 0x1234 at 0x12 and lw -> 0x1234BEEF.
- Misalign: sw to A=0x22 with RegWrite=1 -> memory at 0x20 unchanged (verified by aligned lw), MisalignFault=1, outRegWrite=0. lh at A=0x21 -> same fault.
- Stall/flush: sw 0x55 at 0x30 with Stall=1 -> no write, outputs hold prior values. The same store with FlushSignal=1 and Stall=1 -> no write, outRegWrite=0, outWriteData=0.
- Write-back mux/wrap: MemtoReg=010 with PCplus4In=0x400 -> 0x400; MemtoReg=011 with ShiftLeft16In=0xABCD0000 -> 0xABCD0000. sw at A=0x1000 with ADDR_W=10 aliases to 0x0 -> lw 0x0 returns the stored value.
